// File: rtl/laser_pkg.sv
// Shared definitions for the laser-core host: frame geometry, host states,
// point type and the table-based coverage test.
package laser_pkg;

    localparam int N_POINTS  = 40;
    localparam int RADIUS_SQ = 16;
    localparam int PTR_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SCORE  = 3'd3,
        ST_REPORT = 3'd4
    } host_state_e;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } point_t;

    function automatic logic [3:0] absdiff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Integer points inside radius 4: per |dx| the largest |dy| with dx^2+dy^2 <= 16.
    function automatic logic covered(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic       c;
        dx = absdiff(px, cx);
        dy = absdiff(py, cy);
        case (dx)
            4'd0:       c = (dy <= 4'd4);
            4'd1, 4'd2: c = (dy <= 4'd3);
            4'd3:       c = (dy <= 4'd2);
            4'd4:       c = (dy == 4'd0);
            default:    c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/laser_cover_check.sv
// One point against two circle centres; high when either circle covers it.
module laser_cover_check
    import laser_pkg::*;
(
    input  point_t     pt_i,
    input  logic [3:0] c1x_i,
    input  logic [3:0] c1y_i,
    input  logic [3:0] c2x_i,
    input  logic [3:0] c2y_i,
    output logic       covered_o
);

    // A point inside both circles still yields a single 1.
    always_comb begin
        covered_o = covered(pt_i.x, pt_i.y, c1x_i, c1y_i)
                  | covered(pt_i.x, pt_i.y, c2x_i, c2y_i);
    end

endmodule

// File: rtl/laser_host.sv
// Host for the 40-point laser core: frame buffer, streaming, result capture,
// independent coverage re-scoring and timeout handling.
module laser_host
    import laser_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535,
    parameter int TO_W        = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic       start,
    output logic       busy,
    output logic       LRST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic       res_valid,
    output logic [3:0] res_c1x,
    output logic [3:0] res_c1y,
    output logic [3:0] res_c2x,
    output logic [3:0] res_c2y,
    output logic [5:0] res_score,
    output logic       res_timeout
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_POINTS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    point_t fbuf [N_POINTS];

    host_state_e      state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc_s;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [5:0]       score_q, score_d;
    logic             lrst_q, lrst_d, busy_q, busy_d;
    logic [3:0]       x_q, x_d, y_q, y_d;
    logic             rv_q, rv_d, rto_q, rto_d;
    logic [3:0]       rc1x_q, rc1x_d, rc1y_q, rc1y_d, rc2x_q, rc2x_d, rc2y_q, rc2y_d;
    logic [5:0]       rscore_q, rscore_d;
    logic             cov_s;
    point_t           first_pt_s, next_pt_s, cur_pt_s;

    // Frame buffer: firmware writes only while idle; contents survive reset.
    always_ff @(posedge CLK) begin
        if ((state_q == ST_IDLE) && wr_en && (wr_addr < 6'(N_POINTS))) begin
            fbuf[wr_addr] <= '{x: wr_x, y: wr_y};
        end
    end

    always_comb begin
        ptr_inc_s  = ptr_q + 6'd1;
        first_pt_s = fbuf[0];
        next_pt_s  = fbuf[ptr_inc_s];
        cur_pt_s   = fbuf[ptr_q];
    end

    laser_cover_check u_cover (
        .pt_i      (cur_pt_s),
        .c1x_i     (rc1x_q),
        .c1y_i     (rc1y_q),
        .c2x_i     (rc2x_q),
        .c2y_i     (rc2y_q),
        .covered_o (cov_s)
    );

    // Next-state and datapath decode; LRST and busy follow the next state so they stay registered.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        score_d  = score_q;
        x_d      = x_q;
        y_d      = y_q;
        rv_d     = 1'b0;
        rto_d    = rto_q;
        rc1x_d   = rc1x_q;
        rc1y_d   = rc1y_q;
        rc2x_d   = rc2x_q;
        rc2y_d   = rc2y_q;
        rscore_d = rscore_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    ptr_d   = '0;
                    x_d     = first_pt_s.x;
                    y_d     = first_pt_s.y;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    ptr_d = ptr_inc_s;
                    x_d   = next_pt_s.x;
                    y_d   = next_pt_s.y;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (DONE) begin
                    state_d = ST_SCORE;
                    rc1x_d  = C1X;
                    rc1y_d  = C1Y;
                    rc2x_d  = C2X;
                    rc2y_d  = C2Y;
                    rto_d   = 1'b0;
                    ptr_d   = '0;
                    score_d = 6'd0;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = ST_REPORT;
                    rto_d    = 1'b1;
                    rc1x_d   = 4'd0;
                    rc1y_d   = 4'd0;
                    rc2x_d   = 4'd0;
                    rc2y_d   = 4'd0;
                    rscore_d = 6'd0;
                    rv_d     = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SCORE: begin
                score_d = score_q + {5'd0, cov_s};
                if (ptr_q == PTR_LAST) begin
                    state_d  = ST_REPORT;
                    rscore_d = score_d;
                    rv_d     = 1'b1;
                end else begin
                    ptr_d = ptr_inc_s;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        lrst_d = !((state_d == ST_STREAM) || (state_d == ST_WAIT));
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            score_q  <= 6'd0;
            lrst_q   <= 1'b1;
            busy_q   <= 1'b0;
            x_q      <= 4'd0;
            y_q      <= 4'd0;
            rv_q     <= 1'b0;
            rto_q    <= 1'b0;
            rc1x_q   <= 4'd0;
            rc1y_q   <= 4'd0;
            rc2x_q   <= 4'd0;
            rc2y_q   <= 4'd0;
            rscore_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            lrst_q   <= lrst_d;
            busy_q   <= busy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rv_q     <= rv_d;
            rto_q    <= rto_d;
            rc1x_q   <= rc1x_d;
            rc1y_q   <= rc1y_d;
            rc2x_q   <= rc2x_d;
            rc2y_q   <= rc2y_d;
            rscore_q <= rscore_d;
        end
    end

    assign busy        = busy_q;
    assign LRST        = lrst_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign res_valid   = rv_q;
    assign res_c1x     = rc1x_q;
    assign res_c1y     = rc1y_q;
    assign res_c2x     = rc2x_q;
    assign res_c2y     = rc2y_q;
    assign res_score   = rscore_q;
    assign res_timeout = rto_q;

endmodule

// File: tb/tb_laser_host.sv
// Scoreboard bench for laser_host with a behavioural laser-core model.
module tb_laser_host;
    import laser_pkg::*;

    logic       CLK = 1'b0;
    logic       RST, wr_en, start;
    logic [5:0] wr_addr;
    logic [3:0] wr_x, wr_y;
    logic       busy, LRST, res_valid, res_timeout, DONE;
    logic [3:0] X, Y, res_c1x, res_c1y, res_c2x, res_c2y;
    logic [5:0] res_score;
    logic [3:0] core_c1x = 4'd0, core_c1y = 4'd0, core_c2x = 4'd0, core_c2y = 4'd0;
    logic       done_core = 1'b0, done_poke = 1'b0;
    bit         core_en = 1'b0;

    typedef struct { int c1x; int c1y; int c2x; int c2y; int score; int tmo; } res_t;
    res_t   exp_q[$];
    point_t pt_q[$];
    point_t model_buf [N_POINTS];
    int     n_cmp = 0;
    int     n_bad = 0;

    always #5 CLK = ~CLK;
    assign DONE = done_core | done_poke;

    laser_host #(.TIMEOUT_CYC(100), .TO_W(16)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .start(start), .busy(busy), .LRST(LRST), .X(X), .Y(Y),
        .C1X(core_c1x), .C1Y(core_c1y), .C2X(core_c2x), .C2Y(core_c2y), .DONE(DONE),
        .res_valid(res_valid), .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x),
        .res_c2y(res_c2y), .res_score(res_score), .res_timeout(res_timeout)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit in_rad(input int px, input int py, input int cx, input int cy);
        return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= RADIUS_SQ;
    endfunction

    function automatic int ref_score(input int c1x, input int c1y, input int c2x, input int c2y);
        int s = 0;
        for (int k = 0; k < N_POINTS; k++) begin
            if (in_rad(model_buf[k].x, model_buf[k].y, c1x, c1y) ||
                in_rad(model_buf[k].x, model_buf[k].y, c2x, c2y)) s++;
        end
        return s;
    endfunction

    // Core model: checks the streamed points and returns DONE a few cycles into WAIT.
    initial begin : core_model
        point_t p;
        int     lcnt = 0;
        forever begin
            @(negedge CLK);
            done_core = 1'b0;
            if (LRST == 1'b0) begin
                if (lcnt < N_POINTS) begin
                    if (pt_q.size() > 0) begin
                        p = pt_q.pop_front();
                        check("pt_x", X, p.x);
                        check("pt_y", Y, p.y);
                    end else begin
                        check("pt_unexpected_lrst", LRST, 1);
                    end
                end
                lcnt++;
                if (core_en && (lcnt == N_POINTS + 5)) done_core = 1'b1;
            end else begin
                lcnt = 0;
            end
        end
    end

    // Result monitor: pops the scoreboard on each res_valid.
    initial begin : monitor
        res_t e;
        logic prev_v = 1'b0;
        forever begin
            @(negedge CLK);
            if (res_valid) begin
                check("rv_one_cycle", prev_v, 0);
                if (exp_q.size() == 0) begin
                    check("rv_unexpected", res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_c1x", res_c1x, e.c1x);
                    check("res_c1y", res_c1y, e.c1y);
                    check("res_c2x", res_c2x, e.c2x);
                    check("res_c2y", res_c2y, e.c2y);
                    check("res_score", res_score, e.score);
                    check("res_timeout", res_timeout, e.tmo);
                end
            end
            prev_v = res_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic load_pt(input int a, input int x, input int y);
        wr_en   = 1'b1;
        wr_addr = a[5:0];
        wr_x    = x[3:0];
        wr_y    = y[3:0];
        @(negedge CLK);
        wr_en = 1'b0;
        if (a < N_POINTS) begin
            model_buf[a].x = x[3:0];
            model_buf[a].y = y[3:0];
        end
    endtask

    task automatic launch(input bit en, input int c1x, input int c1y, input int c2x, input int c2y);
        res_t e;
        core_en  = en;
        core_c1x = c1x[3:0];
        core_c1y = c1y[3:0];
        core_c2x = c2x[3:0];
        core_c2y = c2y[3:0];
        for (int k = 0; k < N_POINTS; k++) pt_q.push_back(model_buf[k]);
        if (en) e = '{c1x, c1y, c2x, c2y, ref_score(c1x, c1y, c2x, c2y), 0};
        else    e = '{0, 0, 0, 0, 0, 1};
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_report(output int n);
        n = 1;
        while (!res_valid && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("report_seen", res_valid, 1);
        @(negedge CLK);
        check("idle_lrst", LRST, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic wait_score();
        int n = 0;
        while (!(busy && LRST) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("score_reached", busy & LRST, 1);
    endtask

    task automatic poke_inputs(input int a);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = a[5:0];
        wr_x    = 4'd15;
        wr_y    = 4'd15;
        @(negedge CLK);
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin : main
        int n;
        RST = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = 6'd0; wr_x = 4'd0; wr_y = 4'd0;
        repeat (3) @(negedge CLK);
        check("rst_lrst", LRST, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_timeout", res_timeout, 0);
        check("rst_x", X, 0);
        check("rst_y", Y, 0);
        check("rst_score", res_score, 0);
        check("rst_c1x", res_c1x, 0);
        RST = 1'b0;
        @(negedge CLK);

        // All points on one centre.
        for (int k = 0; k < N_POINTS; k++) load_pt(k, 8, 8);
        launch(1'b1, 8, 8, 0, 0);
        wait_report(n);

        // Ramp pattern exposes skew or duplicated points.
        for (int k = 0; k < N_POINTS; k++) load_pt(k, k % 16, k / 16);
        load_pt(45, 1, 1);
        launch(1'b1, 2, 1, 12, 1);
        wait_report(n);

        // Radius boundary and double coverage.
        for (int k = 0; k < N_POINTS; k++) load_pt(k, 8, 8);
        load_pt(0, 4, 0);
        load_pt(1, 3, 3);
        load_pt(2, 3, 2);
        load_pt(3, 2, 4);
        load_pt(4, 15, 15);
        launch(1'b1, 0, 0, 15, 15);
        wait_report(n);

        // Core never answers.
        launch(1'b0, 0, 0, 0, 0);
        wait_report(n);
        check("timeout_latency", n, 141);

        // start/wr_en while busy, then DONE while idle.
        launch(1'b1, 3, 3, 9, 9);
        repeat (10) @(negedge CLK);
        poke_inputs(0);
        wait_score();
        poke_inputs(1);
        wait_report(n);
        repeat (3) @(negedge CLK);
        done_poke = 1'b1;
        @(negedge CLK);
        done_poke = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_done_busy", busy, 0);
        check("idle_done_c1x", res_c1x, 3);
        check("idle_done_c2y", res_c2y, 9);
        launch(1'b1, 3, 3, 9, 9);
        wait_report(n);

        // Reset in the middle of scoring.
        launch(1'b1, 8, 8, 0, 0);
        wait_score();
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        void'(exp_q.pop_back());
        @(negedge CLK);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_lrst", LRST, 1);
        check("mid_rst_valid", res_valid, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        launch(1'b1, 2, 1, 12, 1);
        wait_report(n);

        repeat (5) @(negedge CLK);
        check("sb_results_left", exp_q.size(), 0);
        check("sb_points_left", pt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
